// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS 8b/10b encoder: two pix_en-gated stages (transition
// minimisation, then DC balancing against a signed running disparity).
module tmds_channel_encoder #(
    parameter int         CNT_W      = 5,
    parameter logic [9:0] RESET_WORD = 10'b1101010100
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    pix_en,
    input  logic                    de_in,
    input  logic [1:0]              ctrl_in,
    input  logic [7:0]              data_in,
    output logic [9:0]              tmds_word,
    output logic signed [CNT_W-1:0] disparity
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // XNOR chain when it produces fewer transitions; q_m[8] records the choice.
    function automatic logic [8:0] min_transition(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic [8:0]              qm_q,   qm_d;
    logic                    de_q,   de_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic [9:0]              word_q, word_d;
    logic signed [CNT_W-1:0] cnt_q,  cnt_d;

    logic [3:0]              n1;
    logic signed [CNT_W-1:0] bal;
    logic signed [CNT_W-1:0] two;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              ctrl_word;

    always_comb begin
        qm_d   = qm_q;
        de_d   = de_q;
        ctrl_d = ctrl_q;
        if (pix_en) begin
            qm_d   = min_transition(data_in);
            de_d   = de_in;
            ctrl_d = ctrl_in;
        end
    end

    always_comb begin
        n1      = popcount8(qm_q[7:0]);
        // bal = n1 - n0 = 2*n1 - 8
        bal     = CNT_W'(n1) + CNT_W'(n1) - CNT_W'(8);
        two     = CNT_W'(2);
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);

        case (ctrl_q)
            2'b00:   ctrl_word = 10'b1101010100;
            2'b01:   ctrl_word = 10'b0010101011;
            2'b10:   ctrl_word = 10'b0101010100;
            default: ctrl_word = 10'b1010101011;
        endcase

        word_d = word_q;
        cnt_d  = cnt_q;
        if (pix_en) begin
            if (!de_q) begin
                word_d = ctrl_word;
                cnt_d  = '0;
            end else if ((cnt_q == '0) || (n1 == 4'd4)) begin
                word_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d  = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
            end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
                word_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d  = cnt_q + (qm_q[8] ? two : '0) - bal;
            end else begin
                word_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d  = cnt_q + bal - (qm_q[8] ? '0 : two);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            word_q <= RESET_WORD;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de_d;
            ctrl_q <= ctrl_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_word = word_q;
    assign disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed and model-checked stimulus for tmds_channel_encoder, including
// enable gating, mid-stream reset and a decode-back check on data symbols.
module tb_tmds_channel_encoder;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              pix_en;
    logic              de_in;
    logic [1:0]        ctrl_in;
    logic [7:0]        data_in;
    logic [9:0]        tmds_word;
    logic signed [4:0] disparity;

    tmds_channel_encoder #(
        .CNT_W      (5),
        .RESET_WORD (10'b1101010100)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pix_en    (pix_en),
        .de_in     (de_in),
        .ctrl_in   (ctrl_in),
        .data_in   (data_in),
        .tmds_word (tmds_word),
        .disparity (disparity)
    );

    always #2 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One pixel period of ten clocks; outputs checked after the enable edge and,
    // when noisy, on every later cycle while the inputs are scrambled.
    task automatic pulse(input logic de, input logic [1:0] ctrl, input logic [7:0] data,
                         input bit noisy, input logic [9:0] exp_w, input int exp_d,
                         input string tag);
        de_in   = de;
        ctrl_in = ctrl;
        data_in = data;
        pix_en  = 1'b1;
        @(negedge clk_in);
        pix_en = 1'b0;
        check({tag, "_word"}, 32'(tmds_word), 32'(exp_w));
        check({tag, "_disp"}, int'(disparity), exp_d);
        for (int i = 0; i < 9; i++) begin
            if (noisy) begin
                data_in = 8'($urandom);
                de_in   = 1'($urandom);
                ctrl_in = 2'($urandom);
            end
            @(negedge clk_in);
            if (noisy) begin
                check({tag, "_hold_word"}, 32'(tmds_word), 32'(exp_w));
                check({tag, "_hold_disp"}, int'(disparity), exp_d);
            end
        end
    endtask

    logic [9:0] ctl_code [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};

    logic       m_de;
    logic [1:0] m_ctrl;
    logic [7:0] m_data;
    int         m_cnt;

    function automatic logic [8:0] ref_qm(input logic [7:0] d);
        int         ones;
        bit         inv;
        logic [8:0] q;
        ones = $countones(d);
        inv  = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = inv ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !inv;
        return q;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    // Running disparity tracked as ones-minus-zeros of every emitted data word.
    task automatic model_step(input logic de, input logic [1:0] ctrl, input logic [7:0] data,
                              output logic [9:0] w, output int d,
                              output logic pde, output logic [7:0] pdata);
        logic [8:0] q;
        int         n1;
        bit         inv;
        if (!m_de) begin
            w     = ctl_code[m_ctrl];
            m_cnt = 0;
        end else begin
            q  = ref_qm(m_data);
            n1 = $countones(q[7:0]);
            if (m_cnt == 0 || n1 == 4) inv = !q[8];
            else if ((m_cnt > 0 && n1 > 4) || (m_cnt < 0 && n1 < 4)) inv = 1'b1;
            else inv = 1'b0;
            w     = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
            m_cnt = m_cnt + 2 * $countones(w) - 10;
        end
        d      = m_cnt;
        pde    = m_de;
        pdata  = m_data;
        m_de   = de;
        m_ctrl = ctrl;
        m_data = data;
    endtask

    typedef struct packed {
        logic              de;
        logic [1:0]        ctrl;
        logic [7:0]        data;
        logic [9:0]        w;
        logic signed [7:0] d;
    } vec_t;

    vec_t tbl [13];

    logic [9:0] ew;
    int         ed;
    logic       pde;
    logic [7:0] pdata;
    logic       rde;
    logic [1:0] rctrl;
    logic [7:0] rdata;
    logic [7:0] gate_data [8] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81, 8'hC3, 8'h10, 8'hFE};

    initial begin
        // Each row's expected word/disparity is the symbol of the previous row.
        tbl = '{
            '{1'b0, 2'd0, 8'h00, 10'b1101010100,  8'sd0},
            '{1'b0, 2'd0, 8'h00, 10'b1101010100,  8'sd0},
            '{1'b0, 2'd0, 8'h00, 10'b1101010100,  8'sd0},
            '{1'b0, 2'd1, 8'h00, 10'b1101010100,  8'sd0},
            '{1'b0, 2'd2, 8'h00, 10'b0010101011,  8'sd0},
            '{1'b0, 2'd3, 8'h00, 10'b0101010100,  8'sd0},
            '{1'b1, 2'd0, 8'h00, 10'b1010101011,  8'sd0},
            '{1'b1, 2'd0, 8'h00, 10'b0100000000, -8'sd8},
            '{1'b1, 2'd0, 8'h00, 10'b1111111111,  8'sd2},
            '{1'b0, 2'd0, 8'h00, 10'b0100000000, -8'sd6},
            '{1'b1, 2'd0, 8'hFF, 10'b1101010100,  8'sd0},
            '{1'b0, 2'd0, 8'h00, 10'b1000000000, -8'sd8},
            '{1'b0, 2'd0, 8'h00, 10'b1101010100,  8'sd0}
        };

        rst_in  = 1'b1;
        pix_en  = 1'b0;
        de_in   = 1'b0;
        ctrl_in = 2'b00;
        data_in = 8'h00;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("reset_word", 32'(tmds_word), 32'(10'b1101010100));
        check("reset_disp", int'(disparity), 0);

        foreach (tbl[i])
            pulse(tbl[i].de, tbl[i].ctrl, tbl[i].data, 1'b0, tbl[i].w, int'(tbl[i].d), "dir");

        pulse(1'b1, 2'd0, 8'h00, 1'b0, 10'b1101010100, 0, "pre_rst");
        pulse(1'b1, 2'd0, 8'h00, 1'b0, 10'b0100000000, -8, "pre_rst");

        // Reset coinciding with an enable must win and discard the in-flight symbol.
        rst_in  = 1'b1;
        pix_en  = 1'b1;
        de_in   = 1'b1;
        data_in = 8'hFF;
        @(negedge clk_in);
        rst_in = 1'b0;
        pix_en = 1'b0;
        check("mid_rst_word", 32'(tmds_word), 32'(10'b1101010100));
        check("mid_rst_disp", int'(disparity), 0);
        repeat (9) @(negedge clk_in);
        pulse(1'b1, 2'd0, 8'h00, 1'b0, 10'b1101010100, 0, "post_rst");
        pulse(1'b1, 2'd0, 8'h00, 1'b0, 10'b0100000000, -8, "post_rst");

        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        m_de   = 1'b0;
        m_ctrl = 2'd0;
        m_data = 8'h00;
        m_cnt  = 0;

        foreach (gate_data[i]) begin
            model_step(1'b1, 2'd0, gate_data[i], ew, ed, pde, pdata);
            pulse(1'b1, 2'd0, gate_data[i], 1'b1, ew, ed, "gate");
        end

        for (int s = 0; s < 1600; s++) begin
            rde   = (s % 800) < 640;
            rctrl = 2'($urandom_range(0, 3));
            rdata = 8'($urandom);
            model_step(rde, rctrl, rdata, ew, ed, pde, pdata);
            pulse(rde, rctrl, rdata, 1'b0, ew, ed, "rand");
            check("rand_bound", 32'(int'(disparity) <= 10 && int'(disparity) >= -10), 32'd1);
            if (pde) check("rand_decode", 32'(tmds_decode(tmds_word)), 32'(pdata));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
